alu_op_sequencer: RTL

//   Command-driven controller that sequences the ALU's two's-complement

---
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Command-driven controller for the ALU's two's-complement arithmetic path.
//   It accepts one ADD/SUB/NEG/ABS command per valid/ready handshake. It runs
//   the command on a single shared WIDTH+1 bit adder over one or two execute
//   cycles. It then holds the result and flags until the consumer accepts them.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   cmd_valid  command present on cmd_op/cmd_a/cmd_b
//   cmd_ready  sequencer can take a command (IDLE only, registered)
//   cmd_op     00 ADD, 01 SUB (a-b), 10 NEG (-a), 11 ABS (|a|)
//   cmd_a      operand a
//   cmd_b      operand b (ignored for NEG/ABS)
//   res_valid  result/flags valid, held until accepted
//   res_ready  consumer accepts the result
//   res        result
//   flag_c     carry out of the adder (bit WIDTH of the sum)
//   flag_v     signed overflow
//   flag_z     res == 0
//   flag_n     res sign bit
//   busy       high in any state other than IDLE
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_EXEC2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Shared adder operand selection. NEG and the negative half of ABS both
    // form ~a + 1, so the adder setup depends only on the latched opcode.
    // Overflow for NEG/ABS only happens when negating the most negative value.
    always_comb begin
        add_x   = {1'b0, a_q};
        add_y   = {1'b0, b_q};
        add_cin = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                add_x   = {1'b0, a_q};
                add_y   = {1'b0, b_q};
                add_cin = 1'b0;
            end
            OP_SUB: begin
                add_x   = {1'b0, a_q};
                add_y   = {1'b0, ~b_q};
                add_cin = 1'b1;
            end
            default: begin
                add_x   = {1'b0, ~a_q};
                add_y   = '0;
                add_cin = 1'b1;
            end
        endcase
        sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

        ovf = 1'b0;
        unique case (op_q)
            OP_ADD:  ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            OP_SUB:  ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            default: ovf = (a_q == MIN_NEG);
        endcase
    end

    // Sequencer FSM with registered handshake outputs and result/flag
    // registers. cmd_ready is registered, so it comes up one cycle after
    // reset is released. The result keeps its value after acceptance
    // until the next command completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        state     <= S_EXEC;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_ABS && !a_q[WIDTH-1]) begin
                        // Non-negative ABS passes a through unchanged.
                        res       <= a_q;
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        flag_z    <= (a_q == '0);
                        flag_n    <= 1'b0;
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                    end else if (op_q == OP_ABS) begin
                        state <= S_EXEC2;
                    end else begin
                        res       <= sum[WIDTH-1:0];
                        flag_c    <= sum[WIDTH];
                        flag_v    <= ovf;
                        flag_z    <= (sum[WIDTH-1:0] == '0);
                        flag_n    <= sum[WIDTH-1];
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                    end
                end
                S_EXEC2: begin
                    res       <= sum[WIDTH-1:0];
                    flag_c    <= sum[WIDTH];
                    flag_v    <= ovf;
                    flag_z    <= (sum[WIDTH-1:0] == '0);
                    flag_n    <= sum[WIDTH-1];
                    state     <= S_DONE;
                    res_valid <= 1'b1;
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
